// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit: turns one fetch request into a single aligned cache line
// read, trims each returned beat by start offset and remaining byte budget,
// right-aligns it and pushes it into the prefetch FIFO. Data-side writes that
// land inside the live code window flush prefetch for a few cycles.

// One output byte lane: picks source byte (lane + shift) and zeroes it when
// the lane lies beyond the byte count of the current push.
module icache_fetch_lane #(
  parameter int DATA_BYTES = 4,
  parameter int OFF_W      = 2,
  parameter int LEN_W      = 5,
  parameter int LANE       = 0
) (
  input  logic [DATA_BYTES-1:0][7:0] beat_bytes,
  input  logic [OFF_W-1:0]           shift,
  input  logic [LEN_W-1:0]           count,
  output logic [7:0]                 lane_byte
);

  logic [OFF_W:0] src;

  // Select the shifted source byte, masked by source range and byte count
  always_comb begin
    src       = (OFF_W+1)'(LANE) + {1'b0, shift};
    lane_byte = 8'd0;
    if ((src < (OFF_W+1)'(DATA_BYTES)) && (LEN_W'(LANE) < count))
      lane_byte = beat_bytes[src[OFF_W-1:0]];
  end

endmodule

module icache_fetch_unit #(
  parameter int DATA_BYTES   = 4,
  parameter int BURST_BEATS  = 4,
  parameter int LEN_W        = 5,
  parameter int RESET_HOLD   = 2,
  parameter int SNOOP_MARGIN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pr_reset,
  input  logic [31:0]               prefetch_address,
  input  logic [31:0]               delivered_eip,
  output logic                      reset_prefetch,
  input  logic                      fetch_do,
  input  logic [31:0]               fetch_address,
  input  logic [LEN_W-1:0]          fetch_length,
  input  logic                      fifo_almost_full,
  output logic                      cache_req,
  output logic [31:0]               cache_addr,
  input  logic                      cache_valid,
  input  logic [8*DATA_BYTES-1:0]   cache_data,
  input  logic                      cache_done,
  output logic                      fifo_write_do,
  output logic [4+8*DATA_BYTES-1:0] fifo_write_data,
  output logic                      prefetched_do,
  output logic [LEN_W-1:0]          prefetched_length,
  input  logic [25:0]               snoop_addr,
  input  logic                      snoop_we
);

  localparam int OFF_W  = $clog2(DATA_BYTES);
  localparam int BEAT_W = $clog2(BURST_BEATS + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [LEN_W-1:0] BEAT_LEN   = LEN_W'(DATA_BYTES);
  localparam logic [31:0]      WIN_EXTENT = 32'(DATA_BYTES * BURST_BEATS + SNOOP_MARGIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              snp_vld_q, snp_vld_d;
  logic [31:0]       snp_addr_q, snp_addr_d;
  logic [31:0]       snp_min_q, snp_min_d;
  logic [31:0]       snp_max_q, snp_max_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic                        flush;
  logic                        req_ok;
  logic                        take_beat;
  logic                        push;
  logic                        snp_hit;
  logic [LEN_W-1:0]            avail;
  logic [LEN_W-1:0]            count;
  logic [OFF_W-1:0]            shift;
  logic [DATA_BYTES-1:0][7:0]  beat_bytes;
  logic [DATA_BYTES-1:0][7:0]  trim_bytes;

  assign flush      = pr_reset | reset_prefetch;
  assign beat_bytes = cache_data;

  // Request qualification and per-beat byte accounting
  always_comb begin
    req_ok    = rst_n && (state_q == IDLE) && !flush && fetch_do &&
                (fetch_length != '0) && !fifo_almost_full;
    take_beat = rst_n && (state_q == READ) && cache_valid && !flush;
    push      = take_beat && (remaining_q != '0);
    avail     = (beat_q == '0) ? (BEAT_LEN - LEN_W'(offset_q)) : BEAT_LEN;
    count     = (avail < remaining_q) ? avail : remaining_q;
    shift     = (beat_q == '0) ? offset_q : '0;
  end

  // Byte lanes: right-align the first beat and cut off bytes past the budget
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    icache_fetch_lane #(
      .DATA_BYTES (DATA_BYTES),
      .OFF_W      (OFF_W),
      .LEN_W      (LEN_W),
      .LANE       (g)
    ) u_lane (
      .beat_bytes (beat_bytes),
      .shift      (shift),
      .count      (count),
      .lane_byte  (trim_bytes[g])
    );
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a flush in READ drains the outstanding read; done wins
  // over flush so a read never waits for a second done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_ok) state_d = READ;
      READ: begin
        if (cache_done)  state_d = IDLE;
        else if (flush)  state_d = DRAIN;
      end
      DRAIN:   if (cache_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request and push strobes, all held low in reset
  always_comb begin
    cache_req         = req_ok;
    cache_addr        = rst_n ? {fetch_address[31:OFF_W], {OFF_W{1'b0}}} : 32'd0;
    fifo_write_do     = push;
    prefetched_do     = push;
    prefetched_length = push ? count : '0;
    fifo_write_data   = push ? {count[3:0], trim_bytes} : '0;
    reset_prefetch    = rst_n && (hold_q != '0);
  end

  // Read bookkeeping: latch offset/budget on accept, consume per valid beat
  always_comb begin
    offset_d    = offset_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    if (req_ok) begin
      offset_d    = fetch_address[OFF_W-1:0];
      remaining_d = fetch_length;
      beat_d      = '0;
    end else if (take_beat) begin
      beat_d = beat_q + BEAT_W'(1);
      if (push) remaining_d = remaining_q - count;
    end
  end

  // Snoop: register write address and window bounds, compare one cycle later,
  // and (re)start the flush hold counter on a hit
  always_comb begin
    snp_vld_d  = snoop_we;
    snp_addr_d = snp_addr_q;
    snp_min_d  = snp_min_q;
    snp_max_d  = snp_max_q;
    if (snoop_we) begin
      snp_addr_d = {4'd0, snoop_addr, 2'd0};
      snp_min_d  = delivered_eip;
      snp_max_d  = prefetch_address + WIN_EXTENT;
    end
    snp_hit = snp_vld_q && (snp_min_q <= snp_addr_q) && (snp_addr_q <= snp_max_q);
    if (snp_hit)              hold_d = HOLD_W'(RESET_HOLD);
    else if (hold_q != '0)    hold_d = hold_q - HOLD_W'(1);
    else                      hold_d = '0;
  end

  // Datapath and snoop registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset_q    <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      snp_vld_q   <= 1'b0;
      snp_addr_q  <= '0;
      snp_min_q   <= '0;
      snp_max_q   <= '0;
      hold_q      <= '0;
    end else begin
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      snp_vld_q   <= snp_vld_d;
      snp_addr_q  <= snp_addr_d;
      snp_min_q   <= snp_min_d;
      snp_max_q   <= snp_max_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed bench for icache_fetch_unit: a 4-byte-beat instance for most cases
// and an 8-byte-beat instance for the wide-beat offset case.
module tb_icache_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pr_reset;
  logic [31:0] prefetch_address;
  logic [31:0] delivered_eip;
  logic        fetch_do4, fetch_do8;
  logic [31:0] fetch_address;
  logic [4:0]  fetch_length4;
  logic [5:0]  fetch_length8;
  logic        fifo_almost_full;
  logic        cache_valid;
  logic [31:0] cache_data4;
  logic [63:0] cache_data8;
  logic        cache_done;
  logic [25:0] snoop_addr;
  logic        snoop_we;

  logic        reset_prefetch4, cache_req4, fifo_write_do4, prefetched_do4;
  logic [31:0] cache_addr4;
  logic [35:0] fifo_write_data4;
  logic [4:0]  prefetched_length4;

  logic        reset_prefetch8, cache_req8, fifo_write_do8, prefetched_do8;
  logic [31:0] cache_addr8;
  logic [67:0] fifo_write_data8;
  logic [5:0]  prefetched_length8;

  int tests = 0;
  int fails = 0;

  icache_fetch_unit #(
    .DATA_BYTES(4), .BURST_BEATS(4), .LEN_W(5), .RESET_HOLD(2), .SNOOP_MARGIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pr_reset(pr_reset),
    .prefetch_address(prefetch_address), .delivered_eip(delivered_eip),
    .reset_prefetch(reset_prefetch4), .fetch_do(fetch_do4),
    .fetch_address(fetch_address), .fetch_length(fetch_length4),
    .fifo_almost_full(fifo_almost_full), .cache_req(cache_req4),
    .cache_addr(cache_addr4), .cache_valid(cache_valid), .cache_data(cache_data4),
    .cache_done(cache_done), .fifo_write_do(fifo_write_do4),
    .fifo_write_data(fifo_write_data4), .prefetched_do(prefetched_do4),
    .prefetched_length(prefetched_length4), .snoop_addr(snoop_addr),
    .snoop_we(snoop_we)
  );

  icache_fetch_unit #(
    .DATA_BYTES(8), .BURST_BEATS(4), .LEN_W(6), .RESET_HOLD(2), .SNOOP_MARGIN(4)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .pr_reset(pr_reset),
    .prefetch_address(prefetch_address), .delivered_eip(delivered_eip),
    .reset_prefetch(reset_prefetch8), .fetch_do(fetch_do8),
    .fetch_address(fetch_address), .fetch_length(fetch_length8),
    .fifo_almost_full(fifo_almost_full), .cache_req(cache_req8),
    .cache_addr(cache_addr8), .cache_valid(cache_valid), .cache_data(cache_data8),
    .cache_done(cache_done), .fifo_write_do(fifo_write_do8),
    .fifo_write_data(fifo_write_data8), .prefetched_do(prefetched_do8),
    .prefetched_length(prefetched_length8), .snoop_addr(snoop_addr),
    .snoop_we(snoop_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat on the 4-byte instance and check the resulting push.
  task automatic beat4(input string tag, input logic [31:0] d, input logic done,
                       input logic exp_push, input logic [4:0] exp_len,
                       input logic [35:0] exp_data);
    cache_valid = 1'b1;
    cache_data4 = d;
    cache_done  = done;
    #1;
    chk({tag, ".push"}, fifo_write_do4, exp_push);
    chk({tag, ".pdo"},  prefetched_do4, exp_push);
    chk({tag, ".len"},  prefetched_length4, exp_len);
    chk({tag, ".data"}, fifo_write_data4, exp_data);
    cyc();
    cache_valid = 1'b0;
    cache_done  = 1'b0;
  endtask

  task automatic beat8(input string tag, input logic [63:0] d, input logic done,
                       input logic [5:0] exp_len, input logic [67:0] exp_data);
    cache_valid = 1'b1;
    cache_data8 = d;
    cache_done  = done;
    #1;
    chk({tag, ".push"}, fifo_write_do8, 1'b1);
    chk({tag, ".len"},  prefetched_length8, exp_len);
    chk({tag, ".data"}, fifo_write_data8, exp_data);
    cyc();
    cache_valid = 1'b0;
    cache_done  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pr_reset = 1'b0;
    prefetch_address = 32'h2008; delivered_eip = 32'h2000;
    fetch_do4 = 1'b1; fetch_do8 = 1'b0; fetch_address = 32'h1000;
    fetch_length4 = 5'd16; fetch_length8 = 6'd0;
    fifo_almost_full = 1'b0; cache_valid = 1'b0; cache_data4 = '0;
    cache_data8 = '0; cache_done = 1'b0; snoop_addr = '0; snoop_we = 1'b0;

    // Reset: outputs forced low even with a request pending
    #2;
    chk("rst.cache_req", cache_req4, 1'b0);
    chk("rst.reset_pf", reset_prefetch4, 1'b0);
    chk("rst.push", fifo_write_do4, 1'b0);
    chk("rst.plen", prefetched_length4, 5'd0);
    cyc(); cyc();
    chk("rst.state", dut.state_q, 2'd0);
    chk("rst.remaining", dut.remaining_q, 5'd0);
    fetch_do4 = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Aligned fetch: 0x1000, 16 bytes
    fetch_do4 = 1'b1; fetch_address = 32'h1000; fetch_length4 = 5'd16;
    #1;
    chk("al.req", cache_req4, 1'b1);
    chk("al.addr", cache_addr4, 32'h1000);
    cyc();
    fetch_do4 = 1'b0;
    #1;
    chk("al.req_off", cache_req4, 1'b0);
    chk("al.state", dut.state_q, 2'd1);
    beat4("al.b0", 32'hAABBCCDD, 1'b0, 1'b1, 5'd4, {4'd4, 32'hAABBCCDD});
    beat4("al.b1", 32'hAABBCCDD, 1'b0, 1'b1, 5'd4, {4'd4, 32'hAABBCCDD});
    beat4("al.b2", 32'hAABBCCDD, 1'b0, 1'b1, 5'd4, {4'd4, 32'hAABBCCDD});
    // Next request is presented during the done beat: must not issue yet
    fetch_do4 = 1'b1; fetch_address = 32'h1003; fetch_length4 = 5'd16;
    #1;
    chk("al.req_in_done", cache_req4, 1'b0);
    beat4("al.b3", 32'hAABBCCDD, 1'b1, 1'b1, 5'd4, {4'd4, 32'hAABBCCDD});
    chk("al.idle", dut.state_q, 2'd0);
    chk("al.rem", dut.remaining_q, 5'd0);

    // Offset 3 fetch: 0x1003, 16 bytes, accepted right after done
    #1;
    chk("o3.req", cache_req4, 1'b1);
    chk("o3.addr", cache_addr4, 32'h1000);
    cyc();
    fetch_do4 = 1'b0;
    beat4("o3.b0", 32'h44332211, 1'b0, 1'b1, 5'd1, {4'd1, 32'h00000044});
    beat4("o3.b1", 32'h88776655, 1'b0, 1'b1, 5'd4, {4'd4, 32'h88776655});
    beat4("o3.b2", 32'h0C0B0A09, 1'b0, 1'b1, 5'd4, {4'd4, 32'h0C0B0A09});
    beat4("o3.b3", 32'h100F0E0D, 1'b1, 1'b1, 5'd4, {4'd4, 32'h100F0E0D});
    chk("o3.rem", dut.remaining_q, 5'd3);
    chk("o3.idle", dut.state_q, 2'd0);

    // Budget trim: 0x1002, 5 bytes -> 2, 3, then silent beats
    fetch_do4 = 1'b1; fetch_address = 32'h1002; fetch_length4 = 5'd5;
    cyc();
    fetch_do4 = 1'b0;
    beat4("bt.b0", 32'h44332211, 1'b0, 1'b1, 5'd2, {4'd2, 32'h00004433});
    beat4("bt.b1", 32'h88776655, 1'b0, 1'b1, 5'd3, {4'd3, 32'h00776655});
    beat4("bt.b2", 32'hCCBBAA99, 1'b0, 1'b0, 5'd0, 36'd0);
    beat4("bt.b3", 32'h11111111, 1'b1, 1'b0, 5'd0, 36'd0);
    chk("bt.idle", dut.state_q, 2'd0);

    // Backpressure and external flush block the request
    fetch_do4 = 1'b1; fetch_address = 32'h3000; fetch_length4 = 5'd4;
    fifo_almost_full = 1'b1;
    #1;
    chk("bp.req", cache_req4, 1'b0);
    cyc();
    chk("bp.state", dut.state_q, 2'd0);
    fifo_almost_full = 1'b0; pr_reset = 1'b1;
    #1;
    chk("prr.req", cache_req4, 1'b0);
    cyc();
    chk("prr.state", dut.state_q, 2'd0);
    pr_reset = 1'b0; fetch_do4 = 1'b0; fetch_length4 = 5'd0;
    #1;
    chk("len0.req", cache_req4, 1'b0);
    fetch_do4 = 1'b1;
    #1;
    chk("len0.req_do", cache_req4, 1'b0);
    fetch_do4 = 1'b0;
    cyc();

    // Snoop flush during a read: window 0x2000..0x201C, write at 0x2018
    fetch_do4 = 1'b1; fetch_address = 32'h2000; fetch_length4 = 5'd16;
    cyc();
    fetch_do4 = 1'b0;
    beat4("sn.b0", 32'h03020100, 1'b0, 1'b1, 5'd4, {4'd4, 32'h03020100});
    snoop_we = 1'b1; snoop_addr = 26'h806;      // cycle t
    #1;
    chk("sn.t", reset_prefetch4, 1'b0);
    cyc();
    snoop_we = 1'b0;                            // t+1
    #1;
    chk("sn.t1", reset_prefetch4, 1'b0);
    cyc();
    beat4("sn.t2", 32'h07060504, 1'b0, 1'b0, 5'd0, 36'd0);
    chk("sn.drain", dut.state_q, 2'd2);
    chk("sn.t3", reset_prefetch4, 1'b1);
    beat4("sn.t3b", 32'h0B0A0908, 1'b0, 1'b0, 5'd0, 36'd0);
    chk("sn.t4", reset_prefetch4, 1'b0);
    chk("sn.still_drain", dut.state_q, 2'd2);
    beat4("sn.t4b", 32'h0F0E0D0C, 1'b1, 1'b0, 5'd0, 36'd0);
    chk("sn.idle", dut.state_q, 2'd0);

    // Control: 0x2020 is outside the window
    snoop_we = 1'b1; snoop_addr = 26'h808;
    cyc();
    snoop_we = 1'b0;
    cyc();
    chk("snc.t2", reset_prefetch4, 1'b0);
    cyc();
    chk("snc.t3", reset_prefetch4, 1'b0);

    // Upper edge 0x201C hits; a second hit at t+1 restarts the hold
    snoop_we = 1'b1; snoop_addr = 26'h807;
    cyc();
    snoop_addr = 26'h800;
    cyc();
    snoop_we = 1'b0;
    chk("snr.t2", reset_prefetch4, 1'b1);
    cyc();
    chk("snr.t3", reset_prefetch4, 1'b1);
    cyc();
    chk("snr.t4", reset_prefetch4, 1'b1);
    cyc();
    chk("snr.t5", reset_prefetch4, 1'b0);

    // pr_reset on the second valid beat drops it; DRAIN until done
    fetch_do4 = 1'b1; fetch_address = 32'h4000; fetch_length4 = 5'd16;
    cyc();
    fetch_do4 = 1'b0;
    beat4("pr.b0", 32'h33221100, 1'b0, 1'b1, 5'd4, {4'd4, 32'h33221100});
    pr_reset = 1'b1;
    beat4("pr.b1", 32'h77665544, 1'b0, 1'b0, 5'd0, 36'd0);
    pr_reset = 1'b0;
    chk("pr.drain", dut.state_q, 2'd2);
    beat4("pr.b2", 32'hBBAA9988, 1'b0, 1'b0, 5'd0, 36'd0);
    beat4("pr.b3", 32'hFFEEDDCC, 1'b1, 1'b0, 5'd0, 36'd0);
    chk("pr.idle", dut.state_q, 2'd0);

    // Wide beats: 8-byte instance, offset 5, 20 bytes -> 3, 8, 8, 1
    fetch_do8 = 1'b1; fetch_address = 32'h5005; fetch_length8 = 6'd20;
    #1;
    chk("w8.req", cache_req8, 1'b1);
    chk("w8.addr", cache_addr8, 32'h5000);
    cyc();
    fetch_do8 = 1'b0;
    beat8("w8.b0", 64'h8877665544332211, 1'b0, 6'd3, {4'd3, 64'h0000000000887766});
    beat8("w8.b1", 64'h0123456789ABCDEF, 1'b0, 6'd8, {4'd8, 64'h0123456789ABCDEF});
    beat8("w8.b2", 64'hFEDCBA9876543210, 1'b0, 6'd8, {4'd8, 64'hFEDCBA9876543210});
    beat8("w8.b3", 64'h0123456789ABCDEF, 1'b1, 6'd1, {4'd1, 64'h00000000000000EF});
    chk("w8.rem", dut8.remaining_q, 6'd0);
    chk("w8.idle", dut8.state_q, 2'd0);

    // Reset in the middle of a read
    fetch_do4 = 1'b1; fetch_address = 32'h6000; fetch_length4 = 5'd16;
    cyc();
    fetch_do4 = 1'b0;
    beat4("mr.b0", 32'h12345678, 1'b0, 1'b1, 5'd4, {4'd4, 32'h12345678});
    rst_n = 1'b0; cache_valid = 1'b1;
    #1;
    chk("mr.push_low", fifo_write_do4, 1'b0);
    cyc();
    cache_valid = 1'b0;
    chk("mr.state", dut.state_q, 2'd0);
    chk("mr.rem", dut.remaining_q, 5'd0);
    rst_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
